// File: rtl/decade_chain_counter.sv
// Multi-digit decade up/down counter with an edge-detected step strobe, parallel load,
// and an optional dekatron-style ripple mode where carries travel one digit per clock.
module decade_chain_counter #(
  parameter int DIGITS = 6,
  parameter int TOP    = 9,
  parameter int RIPPLE = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Clear,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  input  logic                  Request,
  input  logic                  Dec,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Ready,
  output logic                  Done,
  output logic                  Overflow,
  output logic                  Missed,
  output logic                  Zero
);

  localparam int         PW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] TOP_D = 4'(TOP);

  typedef enum logic {S_IDLE, S_PROP} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  dir_q, dir_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  req_q, armed_q;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  missed_q, missed_d;
  logic                  step_edge;
  logic                  carry;
  logic [3:0]            sel_digit;
  logic [4:0]            stepped;

  // Returns {carry_or_borrow, new_digit}; digits loaded above TOP wrap to 0 on increment.
  function automatic logic [4:0] step_digit(input logic [3:0] d, input logic dec);
    if (!dec) return (d >= TOP_D) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    else      return (d == 4'd0)  ? {1'b1, TOP_D} : {1'b0, d - 4'd1};
  endfunction

  // armed_q masks the first clock after reset so a Request already high is not an edge.
  assign step_edge = Request & ~req_q & armed_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    count_d   = count_q;
    state_d   = state_q;
    ptr_d     = ptr_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    missed_d  = 1'b0;
    carry     = 1'b0;
    sel_digit = 4'd0;
    stepped   = 5'd0;

    if (Clear) begin
      count_d = '0;
      state_d = S_IDLE;
      ptr_d   = '0;
    end else if (Load) begin
      count_d = LoadValue;
      state_d = S_IDLE;
      ptr_d   = '0;
    end else if (RIPPLE == 0) begin
      if (step_edge) begin
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
          if (carry) begin
            stepped            = step_digit(count_q[4*k +: 4], Dec);
            count_d[4*k +: 4]  = stepped[3:0];
            carry              = stepped[4];
          end
        end
        done_d = 1'b1;
        ovf_d  = carry;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_edge) begin
            stepped      = step_digit(count_q[3:0], Dec);
            count_d[3:0] = stepped[3:0];
            dir_d        = Dec;
            if (!stepped[4]) begin
              done_d = 1'b1;
            end else if (DIGITS == 1) begin
              done_d = 1'b1;
              ovf_d  = 1'b1;
            end else begin
              state_d = S_PROP;
              ptr_d   = PW'(1);
            end
          end
        end
        S_PROP: begin
          missed_d = step_edge;
          for (int k = 0; k < DIGITS; k++) begin
            if (ptr_q == PW'(k)) sel_digit = count_q[4*k +: 4];
          end
          stepped = step_digit(sel_digit, dir_q);
          for (int k = 0; k < DIGITS; k++) begin
            if (ptr_q == PW'(k)) count_d[4*k +: 4] = stepped[3:0];
          end
          if (!stepped[4]) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (ptr_q == PW'(DIGITS - 1)) begin
            done_d  = 1'b1;
            ovf_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d = ptr_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      req_q    <= 1'b0;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      req_q    <= Request;
      armed_q  <= 1'b1;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
    end
  end

  assign Count    = count_q;
  assign Ready    = (state_q == S_IDLE);
  assign Done     = done_q;
  assign Overflow = ovf_q;
  assign Missed   = missed_q;
  assign Zero     = (count_q == '0);

endmodule

// File: tb/tb_decade_chain_counter.sv
// Scoreboard bench: one parallel and one ripple instance share stimulus; a decimal
// arithmetic model predicts each completed step, monitors compare on every Done pulse.
module tb_decade_chain_counter;

  typedef struct {
    logic [23:0] count;
    logic        ovf;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n, Clear, Load, Request, Dec;
  logic [23:0] LoadValue;
  logic [23:0] count0, count1;
  logic        ready0, ready1, done0, done1, ovf0, ovf1, missed0, missed1, zero0, zero1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   val0 = 0, val1 = 0;
  int   done_cnt0 = 0, done_cnt1 = 0, missed_cnt1 = 0, exp_missed1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 Clk = ~Clk;

  decade_chain_counter #(.DIGITS(6), .TOP(9), .RIPPLE(0)) u_par (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
    .Request(Request), .Dec(Dec), .Count(count0), .Ready(ready0), .Done(done0),
    .Overflow(ovf0), .Missed(missed0), .Zero(zero0));

  decade_chain_counter #(.DIGITS(6), .TOP(9), .RIPPLE(1)) u_rip (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
    .Request(Request), .Dec(Dec), .Count(count1), .Ready(ready1), .Done(done1),
    .Overflow(ovf1), .Missed(missed1), .Zero(zero1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal model: the counter is a number modulo 10^6.
  task automatic push_step(input logic dec, input bit acc0, input bit acc1);
    int nv;
    logic o;
    if (acc0) begin
      o  = dec ? (val0 == 0) : (val0 == 999999);
      nv = dec ? ((val0 + 999999) % 1000000) : ((val0 + 1) % 1000000);
      q0.push_back('{to_bcd(nv), o});
      val0 = nv;
    end
    if (acc1) begin
      o  = dec ? (val1 == 0) : (val1 == 999999);
      nv = dec ? ((val1 + 999999) % 1000000) : ((val1 + 1) % 1000000);
      q1.push_back('{to_bcd(nv), o});
      val1 = nv;
    end else begin
      exp_missed1++;
    end
  endtask

  task automatic wait_ready1();
    for (int c = 0; c < 20 && !ready1; c++) @(negedge Clk);
    if (!ready1) check("ready_timeout", 32'(ready1), 1);
  endtask

  task automatic do_step(input logic dec);
    @(negedge Clk);
    Request = 1'b1;
    Dec     = dec;
    push_step(dec, 1'b1, 1'b1);
    @(negedge Clk);
    Request = 1'b0;
    wait_ready1();
  endtask

  task automatic do_load(input int v);
    @(negedge Clk);
    Load      = 1'b1;
    LoadValue = to_bcd(v);
    @(negedge Clk);
    Load = 1'b0;
    val0 = v;
    val1 = v;
  endtask

  task automatic do_clear();
    @(negedge Clk);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    val0  = 0;
    val1  = 0;
  endtask

  function automatic int pick_value();
    case ($urandom_range(0, 5))
      0:       return 999999;
      1:       return 0;
      2:       return 99999;
      3:       return 100000;
      default: return int'($urandom % 1000000);
    endcase
  endfunction

  // Monitors: pop one expectation per Done pulse.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (done0) begin
        done_cnt0++;
        if (q0.size() == 0) check("par_spurious_done", 1, 0);
        else begin
          exp_t e;
          e = q0.pop_front();
          check("par_count", 32'(count0), 32'(e.count));
          check("par_overflow", 32'(ovf0), 32'(e.ovf));
        end
      end else if (ovf0) check("par_ovf_without_done", 1, 0);
      if (missed0) check("par_missed", 1, 0);
    end
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (done1) begin
        done_cnt1++;
        if (q1.size() == 0) check("rip_spurious_done", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("rip_count", 32'(count1), 32'(e.count));
          check("rip_overflow", 32'(ovf1), 32'(e.ovf));
        end
      end else if (ovf1) check("rip_ovf_without_done", 1, 0);
      if (missed1) missed_cnt1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, low_cnt, done_k, missed_k;
    Rst_n = 1'b0; Clear = 1'b0; Load = 1'b0; LoadValue = '0; Request = 1'b1; Dec = 1'b0;
    #1;
    check("rst_count0", 32'(count0), 0);
    check("rst_count1", 32'(count1), 0);
    check("rst_ready1", 32'(ready1), 1);
    check("rst_ready0", 32'(ready0), 1);
    check("rst_pulses1", 32'({done1, ovf1, missed1}), 0);
    check("rst_zero1", 32'(zero1), 1);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("held_req_no_step0", 32'(count0), 0);
    check("held_req_no_step1", 32'(count1), 0);
    Request = 1'b0;

    // 12 up steps
    d0 = done_cnt0; d1 = done_cnt1;
    repeat (12) do_step(1'b0);
    @(negedge Clk);
    check("t1_count0", 32'(count0), 32'h12);
    check("t1_count1", 32'(count1), 32'h12);
    check("t1_dones0", done_cnt0 - d0, 12);
    check("t1_dones1", done_cnt1 - d1, 12);
    check("t1_zero0", 32'(zero0), 0);

    // 999999 + 1: parallel wraps in one clock, ripple clears one digit per clock
    do_load(999999);
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b0;
    push_step(1'b0, 1'b1, 1'b1);
    low_cnt = 0; done_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        Request = 1'b0;
        check("t2_count0", 32'(count0), 0);
        check("t2_zero0", 32'(zero0), 1);
      end
      if (!ready1) low_cnt++;
      if (done1 && done_k == 0) done_k = k;
      if (k <= 6) check("t3_ripple_digits", 32'(count1), 32'(to_bcd((999999 / 10**k) * 10**k)));
    end
    check("t3_ready_low_cycles", low_cnt, 5);
    check("t3_done_cycle", done_k, 6);

    // 100 - 1 with a second edge during propagation
    do_load(100);
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b1;
    push_step(1'b1, 1'b1, 1'b1);
    done_k = 0; missed_k = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k == 1) Request = 1'b0;
      if (k == 2) begin
        Request = 1'b1;
        push_step(1'b1, 1'b1, 1'b0);
      end
      if (k == 3) Request = 1'b0;
      if (done1 && done_k == 0) done_k = k;
      if (missed1 && missed_k == 0) missed_k = k;
    end
    check("t4_done_cycle", done_k, 3);
    check("t4_missed_cycle", missed_k, 3);
    check("t4_count1", 32'(count1), 32'(to_bcd(val1)));
    check("t4_count0", 32'(count0), 32'(to_bcd(val0)));

    // Request held high: one step only
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b0;
    push_step(1'b0, 1'b1, 1'b1);
    repeat (20) @(negedge Clk);
    Request = 1'b0;
    wait_ready1();
    @(negedge Clk);
    check("t5_held_count0", 32'(count0), 32'(to_bcd(val0)));
    check("t5_held_count1", 32'(count1), 32'(to_bcd(val1)));

    // async reset in the middle of propagation
    do_load(99999);
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b0;
    push_step(1'b0, 1'b1, 1'b1);
    @(negedge Clk);
    Request = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("t5_async_count1", 32'(count1), 0);
    check("t5_async_ready1", 32'(ready1), 1);
    check("t5_async_count0", 32'(count0), 0);
    q0.delete(); q1.delete();
    val0 = 0; val1 = 0;
    @(negedge Clk);
    Rst_n = 1'b1;

    // loaded digit above TOP wraps with carry
    @(negedge Clk);
    Load = 1'b1; LoadValue = 24'h00000C;
    @(negedge Clk);
    Load = 1'b0;
    Request = 1'b1; Dec = 1'b0;
    q0.push_back('{24'h000010, 1'b0});
    q1.push_back('{24'h000010, 1'b0});
    val0 = 10; val1 = 10;
    @(negedge Clk);
    Request = 1'b0;
    wait_ready1();
    @(negedge Clk);
    check("t6_top_wrap0", 32'(count0), 32'h10);
    check("t6_top_wrap1", 32'(count1), 32'h10);

    // Clear beats a simultaneous edge, no Done
    d0 = done_cnt0; d1 = done_cnt1;
    @(negedge Clk);
    Clear = 1'b1; Request = 1'b1;
    @(negedge Clk);
    Clear = 1'b0; Request = 1'b0;
    val0 = 0; val1 = 0;
    repeat (3) @(negedge Clk);
    check("t6_clear0", 32'(count0), 0);
    check("t6_clear1", 32'(count1), 0);
    check("t6_no_done", (done_cnt0 - d0) + (done_cnt1 - d1), 0);

    // randomized operations against the decimal model
    for (int i = 0; i < 80; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 7)       do_step(1'($urandom_range(0, 1)));
      else if (op == 7) do_load(pick_value());
      else if (op == 8) do_clear();
      else repeat ($urandom_range(1, 3)) @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    check("final_count0", 32'(count0), 32'(to_bcd(val0)));
    check("final_count1", 32'(count1), 32'(to_bcd(val1)));
    check("final_zero1", 32'(zero1), 32'(val1 == 0));
    check("pending_q0", q0.size(), 0);
    check("pending_q1", q1.size(), 0);
    check("missed_total", missed_cnt1, exp_missed1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
